// File: rtl/ycbcr_pkg.sv
// Shared definitions for the 4:2:2 YCbCr to RGB converter: capture phases, matrix coefficients, clamp.
// Coefficients for both BT.601 limited range and full range (selected by YCBCR2RGB_FULL_RANGE_EN).
package ycbcr_pkg;

    typedef enum logic [1:0] {
        S_CB = 2'd0,
        S_Y0 = 2'd1,
        S_CR = 2'd2,
        S_Y1 = 2'd3
    } phase_t;

    // BT.601 limited range, 8 fractional bits
    localparam logic signed [19:0] LR_K_Y  = 20'sd298;
    localparam logic signed [19:0] LR_K_RV = 20'sd409;
    localparam logic signed [19:0] LR_K_GU = 20'sd100;
    localparam logic signed [19:0] LR_K_GV = 20'sd208;
    localparam logic signed [19:0] LR_K_BU = 20'sd516;

    // Full range (JPEG), 8 fractional bits
    localparam logic signed [19:0] FR_K_Y  = 20'sd256;
    localparam logic signed [19:0] FR_K_RV = 20'sd359;
    localparam logic signed [19:0] FR_K_GU = 20'sd88;
    localparam logic signed [19:0] FR_K_GV = 20'sd183;
    localparam logic signed [19:0] FR_K_BU = 20'sd454;

    localparam logic signed [9:0]  Y_OFS = 10'sd16;
    localparam logic signed [8:0]  C_OFS = 9'sd128;
    localparam logic signed [19:0] ROUND = 20'sd128;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        if (v < 20'sd0) begin
            return 8'd0;
        end else if (v > 20'sd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/ycbcr_rgb_matrix.sv
// Three-stage YCbCr 4:4:4 to RGB matrix: offset removal, coefficient products, sum/round/clamp.
// Full-range coefficients are used when YCBCR2RGB_FULL_RANGE_EN is defined.
module ycbcr_rgb_matrix
    import ycbcr_pkg::*;
#(
    parameter int COEF_FRAC = 8
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] y,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    output logic       out_valid,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b
);

`ifdef YCBCR2RGB_FULL_RANGE_EN
    localparam logic signed [19:0] K_Y  = FR_K_Y;
    localparam logic signed [19:0] K_RV = FR_K_RV;
    localparam logic signed [19:0] K_GU = FR_K_GU;
    localparam logic signed [19:0] K_GV = FR_K_GV;
    localparam logic signed [19:0] K_BU = FR_K_BU;
    logic signed [9:0] yo_next;
    assign yo_next = $signed({2'b00, y});
`else
    localparam logic signed [19:0] K_Y  = LR_K_Y;
    localparam logic signed [19:0] K_RV = LR_K_RV;
    localparam logic signed [19:0] K_GU = LR_K_GU;
    localparam logic signed [19:0] K_GV = LR_K_GV;
    localparam logic signed [19:0] K_BU = LR_K_BU;
    logic signed [9:0] yo_next;
    assign yo_next = $signed({2'b00, y}) - Y_OFS;
`endif

    logic signed [8:0]  cbo_next, cro_next;
    logic               v1_reg, v2_reg;
    logic signed [9:0]  yo_reg;
    logic signed [8:0]  cbo_reg, cro_reg;
    logic signed [19:0] py_reg, prv_reg, pgu_reg, pgv_reg, pbu_reg;
    logic signed [19:0] sum_r, sum_g, sum_b;

    assign cbo_next = $signed({1'b0, cb}) - C_OFS;
    assign cro_next = $signed({1'b0, cr}) - C_OFS;

    assign sum_r = py_reg + prv_reg + ROUND;
    assign sum_g = py_reg - pgu_reg - pgv_reg + ROUND;
    assign sum_b = py_reg + pbu_reg + ROUND;

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            v1_reg    <= 1'b0;
            yo_reg    <= '0;
            cbo_reg   <= '0;
            cro_reg   <= '0;
            v2_reg    <= 1'b0;
            py_reg    <= '0;
            prv_reg   <= '0;
            pgu_reg   <= '0;
            pgv_reg   <= '0;
            pbu_reg   <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else if (en) begin
            v1_reg    <= in_valid;
            yo_reg    <= yo_next;
            cbo_reg   <= cbo_next;
            cro_reg   <= cro_next;
            v2_reg    <= v1_reg;
            py_reg    <= 20'(yo_reg) * K_Y;
            prv_reg   <= 20'(cro_reg) * K_RV;
            pgu_reg   <= 20'(cbo_reg) * K_GU;
            pgv_reg   <= 20'(cro_reg) * K_GV;
            pbu_reg   <= 20'(cbo_reg) * K_BU;
            out_valid <= v2_reg;
            out_r     <= clamp8(sum_r >>> COEF_FRAC);
            out_g     <= clamp8(sum_g >>> COEF_FRAC);
            out_b     <= clamp8(sum_b >>> COEF_FRAC);
        end
    end

    coef_frac_chk: assert property (@(posedge in_clock) COEF_FRAC == 8);

endmodule

// File: rtl/ycbcr422_to_rgb.sv
// 4:2:2 (Cb,Y0,Cr,Y1) byte stream to RGB pixel stream with valid/ready backpressure.
// Define YCBCR2RGB_FULL_RANGE_EN for full-range decode; default is BT.601 limited range.
module ycbcr422_to_rgb
    import ycbcr_pkg::*;
#(
    parameter int COEF_FRAC        = 8,
    parameter bit PIPE_STALL_CHECK = 1'b1
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b
);

    phase_t     phase_reg, phase_next;
    logic [7:0] cb_reg, y0_reg, cr_reg;
    logic [7:0] iss_y, iss_cr;
    logic       adv, accept, issue;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Pixel0 takes Cr straight from the bus, pixel1 takes Y1 straight from the bus.
    always_comb begin
        phase_next = phase_reg;
        issue      = 1'b0;
        iss_y      = y0_reg;
        iss_cr     = cr_reg;
        if (accept) begin
            if (in_sof) begin
                phase_next = S_Y0;
            end else begin
                case (phase_reg)
                    S_CB: phase_next = S_Y0;
                    S_Y0: phase_next = S_CR;
                    S_CR: begin
                        issue      = 1'b1;
                        iss_cr     = in_data;
                        phase_next = S_Y1;
                    end
                    S_Y1: begin
                        issue      = 1'b1;
                        iss_y      = in_data;
                        phase_next = S_CB;
                    end
                    default: phase_next = S_CB;
                endcase
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            phase_reg <= S_CB;
            cb_reg    <= '0;
            y0_reg    <= '0;
            cr_reg    <= '0;
        end else begin
            phase_reg <= phase_next;
            if (accept) begin
                if (in_sof || phase_reg == S_CB) cb_reg <= in_data;
                if (!in_sof && phase_reg == S_Y0) y0_reg <= in_data;
                if (!in_sof && phase_reg == S_CR) cr_reg <= in_data;
            end
        end
    end

    ycbcr_rgb_matrix #(
        .COEF_FRAC(COEF_FRAC)
    ) u_matrix (
        .in_clock  (in_clock),
        .in_reset_n(in_reset_n),
        .en        (adv),
        .in_valid  (issue),
        .y         (iss_y),
        .cb        (cb_reg),
        .cr        (iss_cr),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    generate
        if (PIPE_STALL_CHECK) begin : g_stall_chk
            hold_chk: assert property (@(posedge in_clock) disable iff (!in_reset_n)
                (out_valid && !out_ready) |=>
                (out_valid && $stable(out_r) && $stable(out_g) && $stable(out_b)));
        end
    endgenerate

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Scoreboard bench for ycbcr422_to_rgb: directed 4:2:2 pairs with hand-computed RGB results.
// Expected values switch with YCBCR2RGB_FULL_RANGE_EN.
module tb_ycbcr422_to_rgb;

    typedef struct {
        logic [7:0]  cb;
        logic [7:0]  y0;
        logic [7:0]  cr;
        logic [7:0]  y1;
        logic [23:0] e0;
        logic [23:0] e1;
    } pair_t;

    logic       in_clock = 1'b0;
    logic       in_reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_r, out_g, out_b;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    pair_t       vecs[$];
    int          mid_idx;

    ycbcr422_to_rgb dut (
        .in_clock  (in_clock),
        .in_reset_n(in_reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [7:0] d, input logic sof);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge in_clock);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1 (data %0h)", d);
        end
        @(negedge in_clock);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_pair(input pair_t p, input logic sof, input logic push);
        if (push) begin
            exp_q.push_back(p.e0);
            exp_q.push_back(p.e1);
        end
        send_beat(p.cb, sof);
        send_beat(p.y0, 1'b0);
        send_beat(p.cr, 1'b0);
        send_beat(p.y1, 1'b0);
    endtask

    // Starting just after an issuing beat was accepted: out_valid must rise in the third cycle.
    task automatic lat_check(input string name);
        #1 check({name, "_c1"}, {31'd0, out_valid}, 32'd0);
        @(negedge in_clock);
        #1 check({name, "_c2"}, {31'd0, out_valid}, 32'd0);
        @(negedge in_clock);
        #1 check({name, "_c3"}, {31'd0, out_valid}, 32'd1);
        @(negedge in_clock);
    endtask

    // Monitor: one pixel transfer per posedge where out_valid & out_ready.
    initial begin
        forever begin
            @(negedge in_clock);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pixel: got %0h expected none", {out_r, out_g, out_b});
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if ({out_r, out_g, out_b} !== e) begin
                        n_bad++;
                        $display("FAIL pixel: got %0h expected %0h", {out_r, out_g, out_b}, e);
                    end else begin
                        $display("ok   pixel: %0h", e);
                    end
                end
            end
        end
    end

    initial begin
`ifdef YCBCR2RGB_FULL_RANGE_EN
        vecs.push_back('{8'd128, 8'd128, 8'd128, 8'd255, 24'h808080, 24'hFFFFFF});
        vecs.push_back('{8'd128, 8'd0,   8'd128, 8'd255, 24'h000000, 24'hFFFFFF});
        vecs.push_back('{8'd160, 8'd128, 8'd100, 8'd200, 24'h5989B9, 24'hA1D1FF});
        mid_idx = 2;
`else
        vecs.push_back('{8'd128, 8'd235, 8'd128, 8'd16,  24'hFFFFFF, 24'h000000});
        vecs.push_back('{8'd90,  8'd81,  8'd240, 8'd81,  24'hFF0000, 24'hFF0000});
        vecs.push_back('{8'd128, 8'd255, 8'd128, 8'd0,   24'hFFFFFF, 24'h000000});
        vecs.push_back('{8'd160, 8'd128, 8'd100, 8'd200, 24'h568DC3, 24'hA9E0FF});
        mid_idx = 3;
`endif

        repeat (3) @(negedge in_clock);
        #1 check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        @(negedge in_clock);
        in_reset_n = 1'b1;

        // Latency of each pixel of the first pair, pipe empty, no stalls
        exp_q.push_back(vecs[0].e0);
        exp_q.push_back(vecs[0].e1);
        send_beat(vecs[0].cb, 1'b1);
        send_beat(vecs[0].y0, 1'b0);
        send_beat(vecs[0].cr, 1'b0);
        lat_check("lat_px0");
        send_beat(vecs[0].y1, 1'b0);
        lat_check("lat_px1");

        // Back-to-back stream of all pairs
        foreach (vecs[i]) send_pair(vecs[i], 1'b1, 1'b1);

        // Backpressure in the middle of a stream
        fork
            begin
                foreach (vecs[i]) send_pair(vecs[i], 1'b1, 1'b1);
            end
            begin
                logic [23:0] held;
                int t = 0;
                repeat (7) @(negedge in_clock);
                out_ready = 1'b0;
                #3;
                while (out_valid !== 1'b1 && t < 20) begin
                    @(negedge in_clock);
                    #3;
                    t++;
                end
                check("stall_has_valid", {31'd0, out_valid}, 32'd1);
                held = {out_r, out_g, out_b};
                repeat (5) begin
                    @(negedge in_clock);
                    #3;
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_hold", {7'd0, out_valid, out_r, out_g, out_b}, {7'd0, 1'b1, held});
                end
                @(negedge in_clock);
                out_ready = 1'b1;
            end
        join

        // Resync: half pair (Cb, Y0) abandoned by a new sof
        send_beat(8'd30, 1'b1);
        send_beat(8'd60, 1'b0);
        send_pair(vecs[mid_idx], 1'b1, 1'b1);

        // Reset with two pixels in flight: nothing may come out
        send_pair(vecs[0], 1'b1, 1'b0);
        in_reset_n = 1'b0;
        @(negedge in_clock);
        in_reset_n = 1'b1;
        #1 check("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flush_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        @(negedge in_clock);
        repeat (6) @(negedge in_clock);

        // Phase must restart at Cb after reset, even without sof
        send_pair(vecs[mid_idx], 1'b0, 1'b1);

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(negedge in_clock);
                t++;
            end
        end
        repeat (4) @(negedge in_clock);
        check("drain_remaining", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ycbcr422_to_rgb.md
Name: ycbcr422_to_rgb

Overview:
- Inverse of the team's RGB→YCbCr 4:4:4 converter.
- Accepts a BT.601 limited-range 8-bit 4:2:2 byte stream (Cb, Y0, Cr, Y1 order), reconstructs 4:4:4 pixel pairs and converts them to 8-bit RGB.
- Sits between the video decode/capture path and the display/framebuffer writer.
- Valid/ready stream on both sides; 3-stage pipeline with backpressure.

Parameters:
- COEF_FRAC, 8, fractional bits of the fixed-point coefficients (only 8 is supported; checked by assertion).
- PIPE_STALL_CHECK, 1, when 1, enable simulation-only assertions on handshake stability.

Ports:
- in_clock  input  1  single clock for all logic.
- in_reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input byte valid.
- in_ready  output  1  block can accept an input byte this cycle.
- in_data  input  8  4:2:2 byte (Cb/Y0/Cr/Y1 per phase).
- in_sof  input  1  qualifies in_data as a Cb byte; forces phase resync.
- out_valid  output  1  RGB pixel valid.
- out_ready  input  1  downstream accepts pixel.
- out_r, out_g, out_b  output  8 each  RGB pixel.

Behaviour:
- Reset (in_reset_n==0 at posedge): out_valid=0, out_r/g/b=0, all pipe valids=0, phase=S_CB, captured Cb/Y0/Cr regs=0. in_ready is combinational; it must not be relied on during reset.
- Reset asserted mid-stream discards all in-flight pixels; no partial pixel is emitted after reset.
- Handshake:
  - Beat accepted when in_valid&in_ready; pixel transferred when out_valid&out_ready.
  - adv = !out_valid | out_ready; in_ready = adv; all pipe stages advance only on adv.
  - Outputs hold stable while out_valid&!out_ready.
- Phase FSM, advances only on an accepted beat:
  - S_CB: capture Cb → S_Y0.
  - S_Y0: capture Y0 → S_CR.
  - S_CR: capture Cr, issue pixel0 (Y0, Cb, Cr) → S_Y1.
  - S_Y1: issue pixel1 (in_data, Cb, Cr) → S_CB.
  - An accepted beat with in_sof=1 is treated as Cb in any state: phase → S_Y0 and any half-built pair is dropped. in_sof only has effect when the beat is accepted.
- Issue means stage-1 valid is set for that cycle. At most one issue per beat, so no internal stall.
- Stage 1: yo = Y−16 (10-bit signed); cbo = Cb−128 and cro = Cr−128 (9-bit signed).
- Stage 2, signed products:
  - 298*yo
  - 409*cro
  - 100*cbo
  - 208*cro
  - 516*cbo
  - 20-bit signed accumulation width.
- Stage 3:
  - R = (298yo + 409cro + 128) >>> 8
  - G = (298yo − 100cbo − 208cro + 128) >>> 8
  - B = (298yo + 516cbo + 128) >>> 8
  - Arithmetic shift; clamp negative to 0 and >255 to 255.
  - Result registered into out_* with out_valid.
- Latency: 3 cycles from the accepted Cr beat (pixel0) or Y1 beat (pixel1) to out_valid, absent stalls.
- Throughput: 2 pixels per 4 accepted beats. Both pipe bubbles and stalls are preserved, with no reordering.

Optional Feature:
- Macro YCBCR2RGB_FULL_RANGE_EN.
- Defined: full-range (JPEG) decode.
  - yo = Y (no −16).
  - R = (256Y + 359cro + 128) >>> 8
  - G = (256Y − 88cbo − 183cro + 128) >>> 8
  - B = (256Y + 454cbo + 128) >>> 8
  - Same clamp and latency.
- Undefined: limited-range BT.601 as above.

Decomposition:
- Shared package ycbcr_pkg holds:
  - phase enum (S_CB, S_Y0, S_CR, S_Y1)
  - coefficient localparams for both ranges
  - Y_OFS=16, C_OFS=128, ROUND=128
  - clamp8 function
- One sub-module, ycbcr_rgb_matrix: stages 1–3 with enable adv, in_valid/out_valid. The top holds the FSM and the 4:2:2 capture.

Test Plan:
- White/black: stream Cb=128, Y0=235, Cr=128, Y1=16 (sof on Cb), out_ready=1 → (255,255,255), then (0,0,0); each at 3 cycles after its issuing beat.
- Red: Cb=90, Y0=81, Cr=240, Y1=81 → two pixels (255,0,0).
- Clamp: Y=255 and Y=0, with Cb=Cr=128 → (255,255,255) and (0,0,0), with no wrap.
- Backpressure: out_ready=0 for 5 cycles mid-stream → in_ready=0 and out_* stable; after release, no pixel lost or duplicated (compare against scoreboard).
- Resync and reset:
  - in_sof mid-pair after Cb, Y0 → half pair dropped; the next pixel uses the new Cb.
  - in_reset_n=0 for 1 cycle with 2 pixels in flight → out_valid=0 next cycle, none emitted.
- With YCBCR2RGB_FULL_RANGE_EN: Y=128, Cb=Cr=128 → (128,128,128); Y=255 → (255,255,255).
